wallace_pipe: RTL
=================

WALLACE_PIPE -- requirements
Module: wallace_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the row and result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter ROWS, default 12, giving the number of partial-product rows (legal 3..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: pp_flat holds a valid operand set.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts pp_flat this cycle.
REQ-007 The block SHALL have port pp_flat, input, ROWS*WIDTH bits: row i occupies bits [i*WIDTH +: WIDTH], two's complement.
REQ-008 The block SHALL have port out_valid, output, 1 bit: sum and carry hold a valid result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the redundant-form sum vector.
REQ-011 The block SHALL have port carry, output, WIDTH bits: the redundant-form carry vector, already aligned (no further shift needed).
REQ-012 The block SHALL have port product, output, WIDTH bits, present only when WALLACE_PIPE_CPA_EN is defined: the resolved sum.

Function
REQ-013 The block SHALL reduce rows with 3:2 carry-save levels: a level with n rows groups floor(n/3) triples into sum/carry pairs and passes the n mod 3 leftover rows through unchanged.
REQ-014 Each carry vector SHALL be shifted left by 1 with zero fill and truncated to WIDTH bits before it enters the next level or the output.
REQ-015 The number of levels L SHALL follow n(k+1) = n(k) - floor(n(k)/3) from n(0) = ROWS until 2 rows remain; this gives L = 5 for ROWS = 12 and L = 1 for ROWS = 3.
REQ-016 A register stage SHALL follow every level, so that latency from accepted input to out_valid is L cycles without an idle stall.
REQ-017 sum + carry SHALL equal the sum of all ROWS rows modulo 2^WIDTH.
REQ-018 Each stage SHALL carry a valid bit alongside its data.
REQ-019 The pipeline SHALL advance globally when advance = !out_valid || out_ready.
REQ-020 in_ready SHALL equal advance; an input is accepted only when in_valid && in_ready.
REQ-021 While advance = 0 (stall), all stage registers, out_valid, sum and carry SHALL hold their values.
REQ-022 When advance = 1, bubbles SHALL propagate as valid = 0, and data in invalid stages is don't-care.
REQ-023 Full throughput SHALL be sustained: one result per cycle when in_valid and out_ready are held high.
REQ-024 A simultaneous output handshake and input acceptance in the same cycle SHALL both take effect, with no lost or duplicated result.
REQ-025 Every accepted input SHALL produce exactly one output handshake, in order.

Reset
REQ-026 When rst_n = 0, all stage valid bits and out_valid SHALL be cleared asynchronously, and all data registers, sum, carry and product SHALL be set to 0.
REQ-027 in_ready SHALL be 1 during and immediately after reset.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight results, and no output handshake for them SHALL occur after reset release.
REQ-029 Reset release SHALL be synchronous to clk; the first acceptance can occur on the first rising edge with rst_n = 1.

Configuration
REQ-030 With macro WALLACE_PIPE_CPA_EN defined, the block SHALL append one registered carry-propagate stage computing product = sum + carry mod 2^WIDTH, giving latency L+1; sum and carry SHALL be registered alongside product in the same final stage, and out_valid SHALL refer to that stage.
REQ-031 Without WALLACE_PIPE_CPA_EN, the product port and the extra stage SHALL be absent and latency SHALL be L.

Verification
REQ-032 Directed test: WIDTH=24, ROWS=12, all rows 24'h000001 -> sum+carry = 24'h00000C with out_valid 5 cycles after acceptance.
REQ-033 Directed test: all rows 24'hFFFFFF -> sum+carry = 24'hFFFFF4; row i = i<<i for i=0..11 -> sum+carry = the exact arithmetic sum truncated to 24 bits.
REQ-034 Directed test: 8 back-to-back inputs with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 5, in order.
REQ-035 Directed test: out_ready=0 for 3 cycles while out_valid=1 -> sum/carry stable, in_ready=0 throughout, no result lost after out_ready returns to 1.
REQ-036 Directed test: rst_n pulsed low with 3 results in flight -> out_valid=0 and outputs=0 immediately, no stale output after release.
REQ-037 Directed test: WALLACE_PIPE_CPA_EN defined, all rows 24'h000001 -> product = 24'h00000C at cycle 6; ROWS=3 -> latency 1 without CPA, 2 with CPA.

Source files
------------

// File: rtl/wallace_pipe.sv
// wallace_pipe: pipelined Wallace-tree carry-save reducer.
// Reduces ROWS two's-complement rows of WIDTH bits to a redundant sum/carry
// pair using 3:2 compressor levels, with a register stage after every level
// and a global valid/ready stall.
// Optional macro WALLACE_PIPE_CPA_EN adds a registered carry-propagate stage
// that drives the 'product' port.

// One 3:2 compressor slice.
// The carry output is already shifted left by one and truncated to WIDTH bits.
module csa32 #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] co
);
  logic [WIDTH-1:0] maj;

  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  assign co  = maj << 1;
endmodule

module wallace_pipe #(
  parameter int WIDTH = 24,
  parameter int ROWS  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] pp_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      sum,
  output logic [WIDTH-1:0]      carry
`ifdef WALLACE_PIPE_CPA_EN
  ,
  output logic [WIDTH-1:0]      product
`endif
);

  // Row count entering level k: each level folds every full triple into a pair.
  function automatic int lvl_rows(input int k);
    int n;
    n = ROWS;
    for (int i = 0; i < k; i++) n = n - n / 3;
    return n;
  endfunction

  // Number of levels needed to reach two rows.
  function automatic int num_lvls(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 2) begin
        n = n - n / 3;
        l++;
      end
    end
    return l;
  endfunction

  localparam int L = num_lvls(ROWS);
`ifdef WALLACE_PIPE_CPA_EN
  localparam int STAGES = L + 1;
`else
  localparam int STAGES = L;
`endif

  logic              advance;
  logic [STAGES:1]   vld_pipe_d, vld_pipe_q;
  logic [WIDTH-1:0]  red_sum, red_carry;

  // The whole pipe moves together; the output slot is free or being drained.
  assign out_valid = vld_pipe_q[STAGES];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Valid shift register: shift in the input valid on advance, hold on stall.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (advance) begin
      vld_pipe_d[1] = in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  // Valid register, cleared asynchronously so in-flight results are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
  end

  // Reduction levels, each followed by its own register stage sized to the
  // number of rows it produces.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NI = lvl_rows(k);
    localparam int NO = lvl_rows(k + 1);
    localparam int T  = NI / 3;

    logic [NI-1:0][WIDTH-1:0] rin;
    logic [NO-1:0][WIDTH-1:0] rout, rows_d, rows_q;

    if (k == 0) begin : g_src
      assign rin = pp_flat;
    end else begin : g_src
      assign rin = g_lvl[k-1].rows_q;
    end

    // Triple j compresses into output rows 2j (sum) and 2j+1 (carry).
    for (genvar j = 0; j < T; j++) begin : g_csa
      csa32 #(.WIDTH(WIDTH)) u_csa (
        .a  (rin[3*j]),
        .b  (rin[3*j+1]),
        .c  (rin[3*j+2]),
        .s  (rout[2*j]),
        .co (rout[2*j+1])
      );
    end

    // Leftover rows ride through untouched behind the compressed pairs.
    for (genvar r = 0; r < NI - 3*T; r++) begin : g_pass
      assign rout[2*T + r] = rin[3*T + r];
    end

    // Capture the level result on advance, hold while stalled.
    always_comb begin
      rows_d = advance ? rout : rows_q;
    end

    // Level data register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rows_q <= '0;
      else        rows_q <= rows_d;
    end
  end

  assign red_sum   = g_lvl[L-1].rows_q[0];
  assign red_carry = g_lvl[L-1].rows_q[1];

`ifdef WALLACE_PIPE_CPA_EN
  logic [WIDTH-1:0] sum_d, sum_q, carry_d, carry_q, product_d, product_q;

  // Final stage: resolve the redundant pair and keep it alongside the product.
  always_comb begin
    sum_d     = sum_q;
    carry_d   = carry_q;
    product_d = product_q;
    if (advance) begin
      sum_d     = red_sum;
      carry_d   = red_carry;
      product_d = red_sum + red_carry;
    end
  end

  // Carry-propagate stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      product_q <= '0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      product_q <= product_d;
    end
  end

  assign sum     = sum_q;
  assign carry   = carry_q;
  assign product = product_q;
`else
  assign sum   = red_sum;
  assign carry = red_carry;
`endif

endmodule
